// File: rtl/cook_timer_ctrl.sv
// ---------------------------------------------------------------------------
// cook_timer_ctrl
//
// Control FSM for a countdown cook timer. It sequences an external BCD
// down-counter chain (load / clear / count-enable strobes), drives the
// heater, and divides the clock down to a one-second count step.
//
// Parameters
//   TICKS_PER_SEC  clock cycles per one-second countdown step (2..2^16)
//
// Ports
//   clock        in   single clock, all state changes on its rising edge
//   clearn       in   asynchronous active-low reset
//   start        in   start / resume request
//   stop         in   pause / cancel request
//   load         in   keypad load request
//   door_closed  in   1 = door closed
//   timer_zero   in   1 = every digit of the counter chain reads 0
//   cnt_loadn    out  load strobe to the counter chain, active-low
//   cnt_clearn   out  clear strobe to the counter chain, active-low
//   cnt_en       out  count enable to the least-significant digit
//   mag_on       out  heater / magnetron drive
//   done         out  one-cycle pulse when the countdown completes
//   state        out  00 IDLE, 01 COOK, 10 PAUSE
//
// Every output is a flop: the next value of each output is computed in the
// same clocked block as the next state, so no input reaches an output
// without passing through a register.
// ---------------------------------------------------------------------------
module cook_timer_ctrl #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic       clock,
   input  logic       clearn,
   input  logic       start,
   input  logic       stop,
   input  logic       load,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic       cnt_loadn,
   output logic       cnt_clearn,
   output logic       cnt_en,
   output logic       mag_on,
   output logic       done,
   output logic [1:0] state
);

   // Prescaler just wide enough to hold TICKS_PER_SEC-1.
   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COOK  = 2'b01,
      PAUSE = 2'b10,
      BAD   = 2'b11
   } state_t;

   state_t        cur;
   logic [PW-1:0] presc;

   assign state = cur;

   // Priority inside every state: an open door vetoes start / keeps cooking
   // off, then stop, then load, then start. Requests that have no meaning in
   // the current state fall through untouched.
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         cur        <= IDLE;
         presc      <= '0;
         cnt_loadn  <= 1'b1;
         cnt_clearn <= 1'b1;
         cnt_en     <= 1'b0;
         mag_on     <= 1'b0;
         done       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; the defaults below are
         // overridden later in the same block, and every reader sees only the
         // values from before this edge.
         cnt_loadn  <= 1'b1;
         cnt_clearn <= 1'b1;
         cnt_en     <= 1'b0;
         mag_on     <= 1'b0;
         done       <= 1'b0;

         case (cur)
            IDLE: begin
               if (stop) begin
                  cnt_clearn <= 1'b0;
               end else if (load) begin
                  // load wins over a simultaneous start
                  cnt_loadn <= 1'b0;
               end else if (start && door_closed && !timer_zero) begin
                  cur    <= COOK;
                  presc  <= '0;
                  mag_on <= 1'b1;
               end
            end

            COOK: begin
               if (!door_closed || stop) begin
                  // Freeze the prescaler so a resume finishes the partial
                  // second instead of restarting it; cnt_en stays low.
                  cur <= PAUSE;
               end else if (timer_zero) begin
                  // cnt_en is held low here so the chain never wraps past 0.
                  cur   <= IDLE;
                  presc <= '0;
                  done  <= 1'b1;
               end else begin
                  mag_on <= 1'b1;
                  if (presc == PRESC_MAX) begin
                     presc  <= '0;
                     cnt_en <= 1'b1;
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
            end

            PAUSE: begin
               if (stop) begin
                  cur        <= IDLE;
                  cnt_clearn <= 1'b0;
               end else if (start && door_closed) begin
                  cur    <= COOK;
                  mag_on <= 1'b1;
               end
            end

            default: begin
               // Unused encoding: fall back to IDLE with all strobes idle.
               cur <= IDLE;
            end
         endcase
      end
   end

endmodule
